// File: rtl/mem_ctrl_pkg.sv
// Shared types for the RAM request front-end: request word, FIFO entry and
// outstanding-request table entry, plus default sizing.
package mem_ctrl_pkg;

   typedef logic [15:0] WORD;

   typedef struct packed {
      logic valid;
      logic we;
      WORD  addr;
   } out_entry_t;

   typedef struct packed {
      logic we;
      WORD  addr;
      WORD  data;
   } mrq_t;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_MAX_OUT = 8;

endpackage

// File: rtl/req_fifo.sv
// In-order request FIFO with a registered not-full flag used directly as the
// client ready, so a push is never accepted while the FIFO is full.
module req_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  mrq_t i_data,
   input  logic i_pop,
   output logic o_ready,
   output logic o_empty,
   output mrq_t o_head
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   mrq_t          r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;
   logic          r_ready;
   logic [AW:0]   w_cnt_nxt;
   logic          w_push;
   logic          w_pop;

   assign w_push    = i_push & r_ready;
   assign w_pop     = i_pop & (r_cnt != '0);
   assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_cnt_nxt != FULL_CNT);
      end
   end

   // Storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   assign o_ready = r_ready;
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/ram_req_scheduler.sv
// Client-facing scheduler: buffers requests in order, issues them to the RAM
// ports while blocking any address already outstanding, and routes acks back.
module ram_req_scheduler
   import mem_ctrl_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MAX_OUT = DEF_MAX_OUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cl_req_valid,
   output logic        cl_req_ready,
   input  logic        cl_req_we,
   input  logic [15:0] cl_req_addr,
   input  logic [15:0] cl_req_data,
   output logic        cl_rd_rsp_valid,
   output logic [15:0] cl_rd_rsp_addr,
   output logic [15:0] cl_rd_rsp_data,
   output logic        cl_wr_ack_valid,
   output logic [15:0] cl_wr_ack_addr,
   output logic        err_unmatched,
   output logic [15:0] wr_address,
   output logic [15:0] wr_data,
   output logic        wr_en,
   input  logic [15:0] wr_ret_address,
   input  logic        wr_ret_ack,
   output logic [15:0] rd_address,
   output logic        rd_en,
   input  logic [15:0] rd_ret_data,
   input  logic [15:0] rd_ret_address,
   input  logic        rd_ret_ack
);

   localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   out_entry_t         r_tbl [MAX_OUT];
   mrq_t               w_req;
   mrq_t               w_head;
   logic               w_ready;
   logic               w_empty;
   logic               w_push;
   logic               w_issue;
   logic               w_hazard;
   logic               w_have_free;
   logic [IW-1:0]      w_free_idx;
   logic [MAX_OUT-1:0] w_wr_hit;
   logic [MAX_OUT-1:0] w_rd_hit;
   logic               w_wr_match;
   logic               w_rd_match;

   assign w_req        = '{we: cl_req_we, addr: cl_req_addr, data: cl_req_data};
   assign w_push       = cl_req_valid & w_ready;
   assign cl_req_ready = w_ready;

   req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_req),
      .i_pop   (w_issue),
      .o_ready (w_ready),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // Descending scan leaves the lowest free slot in w_free_idx.
   always_comb begin
      w_hazard    = 1'b0;
      w_have_free = 1'b0;
      w_free_idx  = '0;
      w_wr_hit    = '0;
      w_rd_hit    = '0;
      for (int i = MAX_OUT-1; i >= 0; i--) begin
         if (r_tbl[i].valid && (r_tbl[i].addr == w_head.addr)) w_hazard = 1'b1;
         if (!r_tbl[i].valid) begin
            w_have_free = 1'b1;
            w_free_idx  = IW'(i);
         end
         w_wr_hit[i] = r_tbl[i].valid &  r_tbl[i].we & (r_tbl[i].addr == wr_ret_address);
         w_rd_hit[i] = r_tbl[i].valid & !r_tbl[i].we & (r_tbl[i].addr == rd_ret_address);
      end
   end

   assign w_wr_match = |w_wr_hit;
   assign w_rd_match = |w_rd_hit;
   assign w_issue    = !w_empty & w_have_free & !w_hazard;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_OUT; i++) r_tbl[i] <= '0;
         wr_en           <= 1'b0;
         rd_en           <= 1'b0;
         wr_address      <= '0;
         wr_data         <= '0;
         rd_address      <= '0;
         cl_wr_ack_valid <= 1'b0;
         cl_wr_ack_addr  <= '0;
         cl_rd_rsp_valid <= 1'b0;
         cl_rd_rsp_addr  <= '0;
         cl_rd_rsp_data  <= '0;
         err_unmatched   <= 1'b0;
      end else begin
         // An allocated slot was free, so it can never be one being freed.
         for (int i = 0; i < MAX_OUT; i++) begin
            if (w_issue && (w_free_idx == IW'(i)))
               r_tbl[i] <= '{valid: 1'b1, we: w_head.we, addr: w_head.addr};
            else if ((wr_ret_ack && w_wr_hit[i]) || (rd_ret_ack && w_rd_hit[i]))
               r_tbl[i].valid <= 1'b0;
         end

         wr_en <= w_issue &  w_head.we;
         rd_en <= w_issue & !w_head.we;
         if (w_issue && w_head.we) begin
            wr_address <= w_head.addr;
            wr_data    <= w_head.data;
         end
         if (w_issue && !w_head.we) rd_address <= w_head.addr;

         cl_wr_ack_valid <= wr_ret_ack & w_wr_match;
         if (wr_ret_ack && w_wr_match) cl_wr_ack_addr <= wr_ret_address;

         cl_rd_rsp_valid <= rd_ret_ack & w_rd_match;
         if (rd_ret_ack && w_rd_match) begin
            cl_rd_rsp_addr <= rd_ret_address;
            cl_rd_rsp_data <= rd_ret_data;
         end

         if ((wr_ret_ack && !w_wr_match) || (rd_ret_ack && !w_rd_match))
            err_unmatched <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_req_scheduler.sv
// Bench for ram_req_scheduler: queue-based reference model compared every
// cycle, a RAM responder with random ack delays, and directed scenarios.
module tb_ram_req_scheduler;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cl_req_valid = 1'b0, cl_req_we = 1'b0;
   logic [15:0] cl_req_addr = '0, cl_req_data = '0;
   logic        cl_req_ready, cl_rd_rsp_valid, cl_wr_ack_valid, err_unmatched;
   logic [15:0] cl_rd_rsp_addr, cl_rd_rsp_data, cl_wr_ack_addr;
   logic [15:0] wr_address, wr_data, rd_address;
   logic        wr_en, rd_en;
   logic [15:0] wr_ret_address = '0, rd_ret_data = '0, rd_ret_address = '0;
   logic        wr_ret_ack = 1'b0, rd_ret_ack = 1'b0;

   ram_req_scheduler #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .reset(reset),
      .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready),
      .cl_req_we(cl_req_we), .cl_req_addr(cl_req_addr), .cl_req_data(cl_req_data),
      .cl_rd_rsp_valid(cl_rd_rsp_valid), .cl_rd_rsp_addr(cl_rd_rsp_addr),
      .cl_rd_rsp_data(cl_rd_rsp_data),
      .cl_wr_ack_valid(cl_wr_ack_valid), .cl_wr_ack_addr(cl_wr_ack_addr),
      .err_unmatched(err_unmatched),
      .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en),
      .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
      .rd_address(rd_address), .rd_en(rd_en),
      .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      nvec++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {bit we; logic [15:0] addr; logic [15:0] data;} treq_t;
   typedef struct {bit we; logic [15:0] addr;} tout_t;

   treq_t mq[$];
   tout_t ot[$];
   bit          exp_ready = 0, exp_wr_en = 0, exp_rd_en = 0, exp_wack = 0, exp_rsp = 0, exp_err = 0;
   logic [15:0] exp_wr_addr = '0, exp_wr_data = '0, exp_rd_addr = '0;
   logic [15:0] exp_wack_addr = '0, exp_rsp_addr = '0, exp_rsp_data = '0;
   int    m_idx;
   bit    m_iss;
   treq_t m_rq;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete(); ot.delete();
         exp_ready = 0; exp_wr_en = 0; exp_rd_en = 0; exp_wack = 0; exp_rsp = 0; exp_err = 0;
         exp_wr_addr = '0; exp_wr_data = '0; exp_rd_addr = '0;
         exp_wack_addr = '0; exp_rsp_addr = '0; exp_rsp_data = '0;
      end else begin
         // Issue eligibility is judged on the state before this edge.
         m_iss = (mq.size() != 0) && (ot.size() < MAX_OUT);
         if (m_iss) foreach (ot[k]) if (ot[k].addr == mq[0].addr) m_iss = 0;
         exp_wack = 0; exp_rsp = 0; exp_wr_en = 0; exp_rd_en = 0;
         if (wr_ret_ack) begin
            m_idx = -1;
            foreach (ot[k]) if (ot[k].we && ot[k].addr == wr_ret_address) m_idx = k;
            if (m_idx >= 0) begin
               ot.delete(m_idx); exp_wack = 1; exp_wack_addr = wr_ret_address;
            end else exp_err = 1;
         end
         if (rd_ret_ack) begin
            m_idx = -1;
            foreach (ot[k]) if (!ot[k].we && ot[k].addr == rd_ret_address) m_idx = k;
            if (m_idx >= 0) begin
               ot.delete(m_idx); exp_rsp = 1;
               exp_rsp_addr = rd_ret_address; exp_rsp_data = rd_ret_data;
            end else exp_err = 1;
         end
         if (m_iss) begin
            m_rq = mq.pop_front();
            ot.push_back('{we: m_rq.we, addr: m_rq.addr});
            if (m_rq.we) begin exp_wr_en = 1; exp_wr_addr = m_rq.addr; exp_wr_data = m_rq.data; end
            else begin exp_rd_en = 1; exp_rd_addr = m_rq.addr; end
         end
         if (cl_req_valid && exp_ready)
            mq.push_back('{we: cl_req_we, addr: cl_req_addr, data: cl_req_data});
         exp_ready = (mq.size() != DEPTH);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready",     cl_req_ready,    exp_ready);
         chk("wr_en",     wr_en,           exp_wr_en);
         chk("rd_en",     rd_en,           exp_rd_en);
         chk("wr_addr",   wr_address,      exp_wr_addr);
         chk("wr_data",   wr_data,         exp_wr_data);
         chk("rd_addr",   rd_address,      exp_rd_addr);
         chk("wack",      cl_wr_ack_valid, exp_wack);
         chk("wack_addr", cl_wr_ack_addr,  exp_wack_addr);
         chk("rsp",       cl_rd_rsp_valid, exp_rsp);
         chk("rsp_addr",  cl_rd_rsp_addr,  exp_rsp_addr);
         chk("rsp_data",  cl_rd_rsp_data,  exp_rsp_data);
         chk("err",       err_unmatched,   exp_err);
      end
   end

   // ---------------- RAM responder ----------------
   logic [15:0] ram [logic [15:0]];
   logic [31:0] wpend[$];
   logic [15:0] rpend[$];
   bit auto_ack = 0, force_wr = 0, force_rd = 0, inj_rd = 0;
   logic [15:0] inj_addr = '0;
   int tcount = 0, n_wr = 0, n_rd = 0, n_rsp = 0;
   int last_wr_tick = 0, last_rd_tick = 0, last_wack_tick = 0, last_rsp_tick = 0;
   logic [15:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0, last_rsp_data = '0;
   int rd_ticks[$];

   function automatic logic [15:0] ram_rd(input logic [15:0] a);
      return ram.exists(a) ? ram[a] : (a ^ 16'h5A5A);
   endfunction

   task automatic tick();
      logic [31:0] w;
      logic [15:0] a;
      @(negedge clk);
      tcount++;
      if (wr_en) begin
         wpend.push_back({wr_address, wr_data}); n_wr++;
         last_wr_tick = tcount; last_wr_addr = wr_address; last_wr_data = wr_data;
      end
      if (rd_en) begin
         rpend.push_back(rd_address); n_rd++;
         last_rd_tick = tcount; last_rd_addr = rd_address; rd_ticks.push_back(tcount);
      end
      if (cl_wr_ack_valid) last_wack_tick = tcount;
      if (cl_rd_rsp_valid) begin
         n_rsp++; last_rsp_tick = tcount; last_rsp_data = cl_rd_rsp_data;
         chk("rsp_vs_ram", cl_rd_rsp_data, ram_rd(cl_rd_rsp_addr));
      end
      wr_ret_ack = 0; rd_ret_ack = 0;
      if (wpend.size() != 0 && (force_wr || (auto_ack && $urandom_range(0, 3) != 0))) begin
         w = wpend.pop_front();
         ram[w[31:16]] = w[15:0];
         wr_ret_ack = 1; wr_ret_address = w[31:16];
      end
      if (inj_rd) begin
         rd_ret_ack = 1; rd_ret_address = inj_addr; rd_ret_data = 16'hDEAD;
      end else if (rpend.size() != 0 && (force_rd || (auto_ack && $urandom_range(0, 3) != 0))) begin
         a = rpend.pop_front();
         rd_ret_ack = 1; rd_ret_address = a; rd_ret_data = ram_rd(a);
      end
      force_wr = 0; force_rd = 0; inj_rd = 0;
   endtask

   task automatic push_req(input bit we, input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      cl_req_valid = 1; cl_req_we = we; cl_req_addr = a; cl_req_data = d;
      while (!cl_req_ready && n < 300) begin tick(); n++; end
      chk("push_bound", 32'(n < 300), 32'd1);
      tick();
      cl_req_valid = 0;
   endtask

   task automatic wait_drain();
      int n = 0;
      auto_ack = 1;
      while ((mq.size() != 0 || ot.size() != 0 || wpend.size() != 0 || rpend.size() != 0) && n < 3000) begin
         tick(); n++;
      end
      chk("drain_bound", 32'(n < 3000), 32'd1);
      tick(); tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   int t0, n0;

   initial begin
      reset = 1;
      tick(); tick();
      chk_en = 1;
      chk("rst_ready", cl_req_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_err", err_unmatched, 0);
      reset = 0;
      tick();
      chk("ready_after_rst", cl_req_ready, 1);

      // write then read of the same address; read must wait for the write ack
      auto_ack = 0; n0 = n_rd;
      push_req(1, 16'h0010, 16'hBEEF);
      push_req(0, 16'h0010, 16'h0000);
      repeat (5) tick();
      chk("wr_first_addr", last_wr_addr, 16'h0010);
      chk("wr_first_data", last_wr_data, 16'hBEEF);
      chk("raw_blocked", n_rd - n0, 0);
      force_wr = 1; tick(); t0 = tcount;
      tick(); tick();
      chk("wack_latency", last_wack_tick - t0, 1);
      chk("raw_issue_latency", last_rd_tick - t0, 2);
      chk("raw_rd_addr", last_rd_addr, 16'h0010);
      force_rd = 1; tick(); t0 = tcount;
      tick();
      chk("rsp_latency", last_rsp_tick - t0, 1);
      chk("rsp_beef", last_rsp_data, 16'hBEEF);

      // four independent reads back-to-back
      n0 = n_rd; t0 = n_rsp;
      for (int a = 1; a <= 4; a++) push_req(0, 16'(a), 16'h0000);
      repeat (3) tick();
      chk("b2b_count", n_rd - n0, 4);
      chk("b2b_consecutive", rd_ticks[rd_ticks.size()-1] - rd_ticks[rd_ticks.size()-4], 3);
      chk("b2b_last_addr", last_rd_addr, 16'h0004);
      wait_drain();
      chk("b2b_rsp_count", n_rsp - t0, 4);

      // full FIFO behind a blocked head
      auto_ack = 0;
      push_req(1, 16'h0040, 16'h0001);
      tick(); tick();
      push_req(1, 16'h0040, 16'h0002);
      push_req(1, 16'h0041, 16'h0003);
      push_req(1, 16'h0042, 16'h0004);
      push_req(1, 16'h0043, 16'h0005);
      chk("full_ready_low", cl_req_ready, 0);
      cl_req_valid = 1; cl_req_we = 1; cl_req_addr = 16'h0044; cl_req_data = 16'h0006;
      repeat (3) begin tick(); chk("full_hold", cl_req_ready, 0); end
      force_wr = 1; tick(); t0 = tcount;
      tick(); tick();
      chk("head_reissue", last_wr_tick - t0, 2);
      chk("ready_back", cl_req_ready, 1);
      tick();
      cl_req_valid = 0;
      wait_drain();

      // table full: ninth read waits for a free entry
      auto_ack = 0; n0 = n_rd;
      for (int i = 0; i < 9; i++) push_req(0, 16'h0100 + 16'(i), 16'h0000);
      repeat (4) tick();
      chk("tbl_full_stall", n_rd - n0, 8);
      force_rd = 1; tick(); t0 = tcount;
      tick(); tick();
      chk("tbl_free_issue", last_rd_tick - t0, 2);
      chk("tbl_ninth_addr", last_rd_addr, 16'h0108);
      wait_drain();

      // simultaneous write ack and read ack
      auto_ack = 0;
      push_req(1, 16'h0020, 16'h1234);
      push_req(0, 16'h0030, 16'h0000);
      repeat (3) tick();
      force_wr = 1; force_rd = 1; tick(); t0 = tcount;
      tick();
      chk("sim_wack", last_wack_tick - t0, 1);
      chk("sim_rsp", last_rsp_tick - t0, 1);
      chk("sim_wack_addr", cl_wr_ack_addr, 16'h0020);
      chk("sim_rsp_addr", cl_rd_rsp_addr, 16'h0030);
      wait_drain();

      // randomized traffic over a small address space to provoke hazards
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 2) == 0)
            push_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom));
         else
            tick();
      end
      wait_drain();

      // unmatched ack with an empty table
      n0 = n_rsp;
      inj_rd = 1; inj_addr = 16'h0099; tick();
      tick();
      chk("unm_no_rsp", cl_rd_rsp_valid, 0);
      chk("unm_err", err_unmatched, 1);
      repeat (3) tick();
      chk("unm_sticky", err_unmatched, 1);
      chk("unm_rsp_count", n_rsp - n0, 0);

      // reset mid-operation; stale RAM acks come back unmatched
      auto_ack = 0;
      push_req(1, 16'h0050, 16'h5555);
      push_req(0, 16'h0060, 16'h0000);
      repeat (3) tick();
      reset = 1; tick(); tick();
      chk("rst2_wr_en", wr_en, 0);
      chk("rst2_rd_en", rd_en, 0);
      chk("rst2_err", err_unmatched, 0);
      chk("rst2_ready", cl_req_ready, 0);
      chk("rst2_wr_addr", wr_address, 0);
      chk("rst2_rd_addr", rd_address, 0);
      chk("rst2_rsp_data", cl_rd_rsp_data, 0);
      reset = 0; tick();
      chk("rst2_ready_up", cl_req_ready, 1);
      force_wr = 1; force_rd = 1; tick();
      tick();
      chk("stale_no_wack", cl_wr_ack_valid, 0);
      chk("stale_no_rsp", cl_rd_rsp_valid, 0);
      chk("stale_err", err_unmatched, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
